fdct_row: RTL and testbench

FDCT_ROW -- requirements
Module: fdct_row

---
 rtl/fdct_row.sv | 189 ++++++++++++++++++
 tb/tb_fdct_row.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdct_row.sv
// fdct_row: 8-point 1-D forward DCT, one MAC per cycle, shift-add constant products.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   in_data    signed sample x[n] (DW bits)
//   in_valid   in_data valid
//   in_ready   block accepts a sample this cycle (high while loading)
//   out_data   signed coefficient y[k] (DW+4 bits), rounded (S_k + 1024) >>> 11
//   out_valid  out_data valid, held until out_ready
//   out_ready  consumer accepts out_data this cycle
//   out_last   high with out_valid for k = 7
//
// Flow: LOAD collects 8 samples, CALC accumulates one coefficient over 8 cycles,
// OUT presents it; OUT returns to CALC for the next k or to LOAD after k = 7.
module fdct_row #(
  parameter int DW = 12,
  parameter int AW = DW + 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW+3:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int unsigned OW    = DW + 4;
  localparam int unsigned NPTS  = 8;
  localparam int unsigned SHIFT = 11;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            k_q, k_d;
  logic [2:0]            n_q, n_d;
  logic [4:0]            phase_q, phase_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  x_q [NPTS];
  logic signed [DW-1:0]  x_d [NPTS];
  logic signed [OW-1:0]  out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  // Coefficient selection and product
  logic [4:0]            fold1;
  logic [3:0]            m_idx;
  logic                  neg;
  logic signed [AW-1:0]  xs;
  logic signed [AW-1:0]  mag;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  rnd;

  localparam logic signed [AW-1:0] HALF = AW'(1024);

  // phase_q tracks ((2n+1)*k) mod 32 incrementally: starts at k, steps by 2k.
  // Fold into the first quadrant index 0..8; m = 0 (k = 0) maps to 2048.
  always_comb begin
    fold1 = (phase_q > 5'd16) ? (5'd0 - phase_q) : phase_q;
    neg   = 1'b0;
    m_idx = fold1[3:0];
    if (fold1 > 5'd8) begin
      m_idx = 4'(5'd16 - fold1);
      neg   = 1'b1;
    end
  end

  // Shift-add constant multiply of the current sample by W(m_idx)
  always_comb begin
    xs = AW'(x_q[n_q]);
    case (m_idx)
      4'd1:    mag = (xs <<< 11) + (xs <<< 9) + (xs <<< 8) + (xs <<< 4) + (xs <<< 3) + xs;
      4'd2:    mag = (xs <<< 11) + (xs <<< 9) + (xs <<< 6) + (xs <<< 5) + (xs <<< 4) + (xs <<< 2);
      4'd3:    mag = (xs <<< 11) + (xs <<< 8) + (xs <<< 6) + (xs <<< 5) + (xs <<< 3);
      4'd5:    mag = (xs <<< 10) + (xs <<< 9) + (xs <<< 6) + (xs <<< 3) + xs;
      4'd6:    mag = (xs <<< 10) + (xs <<< 6) + (xs <<< 4) + (xs <<< 2);
      4'd7:    mag = (xs <<< 9) + (xs <<< 5) + (xs <<< 4) + (xs <<< 2) + xs;
      default: mag = (xs <<< 11);
    endcase
    prod = neg ? -mag : mag;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    n_d        = n_q;
    phase_d    = phase_q;
    acc_d      = acc_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    rnd        = '0;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          x_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = CALC;
            k_d     = 3'd0;
            n_d     = 3'd0;
            phase_d = 5'd0;
          end
        end
      end
      CALC: begin
        acc_d   = ((n_q == 3'd0) ? '0 : acc_q) + prod;
        n_d     = n_q + 3'd1;
        phase_d = phase_q + {1'b0, k_q, 1'b0};
        if (n_q == 3'd7) begin
          rnd        = acc_d + HALF;
          out_data_d = OW'(rnd >>> SHIFT);
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (k_q == 3'd7) begin
            state_d = LOAD;
            cnt_d   = 3'd0;
            k_d     = 3'd0;
          end else begin
            state_d = CALC;
            k_d     = k_q + 3'd1;
            n_d     = 3'd0;
            phase_d = {2'b00, k_q} + 5'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 3'd0;
      end
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
    out_last_d  = (state_d == OUT) && (k_d == 3'd7);
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      phase_q     <= 5'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      n_q         <= n_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample buffer; only ever read after being written during LOAD
  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fdct_row.sv
// tb_fdct_row: randomized and directed bench for fdct_row against a reference DCT model.
module tb_fdct_row;

  localparam int DW = 12;
  localparam int OW = DW + 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_last;

  always #5 clk = ~clk;

  fdct_row #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_ref   = 0;
  int ld      = 0;
  int xb [8];
  int exp_d [$];
  bit exp_l [$];
  int log_q [$];
  int rdy_mode = 0;
  bit ev;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference coefficient straight from the cosine-index folding rule
  function automatic int coef(input int k, input int n);
    int m;
    int w;
    bit ng;
    if (k == 0) return 2048;
    m  = ((2 * n + 1) * k) % 32;
    ng = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m  = 16 - m;
      ng = 1'b1;
    end
    case (m)
      1: w = 2841;
      2: w = 2676;
      3: w = 2408;
      4: w = 2048;
      5: w = 1609;
      6: w = 1108;
      7: w = 565;
      default: w = 0;
    endcase
    return ng ? -w : w;
  endfunction

  function automatic int dct(input int xs [8], input int k);
    longint s;
    s = 0;
    for (int n = 0; n < 8; n++) s += longint'(xs[n]) * longint'(coef(k, n));
    return int'((s + 1024) >>> 11);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Out-ready pattern generator (mode 2 leaves out_ready to the main sequence)
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(3) != 0);
  end

  // Compare process: in_ready, out_valid timing, data and last every cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
      ld = 0;
    end else begin
      ev = (exp_d.size() > 0) && (cyc >= t_ref + 9);
      chk("in_ready", int'(in_ready), (exp_d.size() == 0) ? 1 : 0);
      chk("out_valid", int'(out_valid), int'(ev));
      chk("out_last", int'(out_last), ev ? int'(exp_l[0]) : 0);
      if (ev && out_valid) begin
        chk("out_data", int'(out_data), exp_d[0]);
        if (out_ready) begin
          log_q.push_back(int'(out_data));
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          t_ref = cyc;
        end
      end
      if (in_valid && in_ready) begin
        xb[ld] = int'(in_data);
        ld++;
        if (ld == 8) begin
          for (int k = 0; k < 8; k++) begin
            exp_d.push_back(dct(xb, k));
            exp_l.push_back(k == 7);
          end
          t_ref = cyc;
          ld = 0;
        end
      end
    end
  end

  // Drive 8 samples; entry and exit at posedge+1
  task automatic send_block(input int xs [8], input bit gaps);
    int t;
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom_range(2) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(xs[i]);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("load_timeout", 0, 1);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_d.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_d.size() > 0) chk("drain_timeout", exp_d.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_dir(input string nm, input int xs [8], input int e [8]);
    log_q.delete();
    send_block(xs, 1'b0);
    in_valid = 1'b0;
    drain();
    chk({nm, "_count"}, log_q.size(), 8);
    if (log_q.size() == 8)
      for (int k = 0; k < 8; k++) chk(nm, log_q[k], e[k]);
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(15));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(4095)) - 2048;
  endfunction

  int x100 [8]  = '{100, 100, 100, 100, 100, 100, 100, 100};
  int e100 [8]  = '{800, 0, 0, 0, 0, 0, 0, 0};
  int ximp [8]  = '{1000, 0, 0, 0, 0, 0, 0, 0};
  int eimp [8]  = '{1000, 1387, 1307, 1176, 1000, 786, 541, 276};
  int xneg [8]  = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
  int eneg [8]  = '{-16384, 0, 0, 0, 0, 0, 0, 0};
  int xr [8];
  int t;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);

    // Pin the reference model to hand-computed values
    for (int k = 0; k < 8; k++) begin
      chk("model_imp", dct(ximp, k), eimp[k]);
      chk("model_dc", dct(x100, k), e100[k]);
    end
    chk("model_neg0", dct(xneg, 0), -16384);
    @(posedge clk); #1;

    rdy_mode = 0;
    run_dir("dc100", x100, e100);
    run_dir("impulse", ximp, eimp);
    run_dir("neg_full", xneg, eneg);

    // Stall at y[3] for 20 cycles with in_valid noise
    rdy_mode = 2;
    out_ready = 1'b0;
    log_q.delete();
    send_block(ximp, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!out_valid && t < 100);
      if (!out_valid) chk("stall_wait", 0, 1);
      if (k == 3) begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          in_valid = ($urandom_range(1) == 1);
          in_data  = DW'(rnd_sample());
          @(negedge clk);
          chk("stall_data", int'(out_data), 1176);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
        end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    drain();
    chk("stall_count", log_q.size(), 8);
    if (log_q.size() == 8)
      for (int k = 0; k < 8; k++) chk("stall_seq", log_q[k], eimp[k]);

    // Back-to-back blocks with in_valid held high
    rdy_mode = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) xr[i] = rnd_sample();
      send_block(xr, 1'b0);
    end
    in_valid = 1'b0;
    drain();

    // Reset during CALC for k = 2, then a fresh block
    log_q.delete();
    for (int i = 0; i < 8; i++) xr[i] = rnd_sample();
    send_block(xr, 1'b0);
    in_valid = 1'b0;
    t = 0;
    while (log_q.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reach", (log_q.size() >= 2) ? 1 : 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run_dir("after_rst", x100, e100);

    // Randomized blocks with input gaps and output backpressure
    for (int b = 0; b < 16; b++) begin
      rdy_mode = b % 2;
      for (int i = 0; i < 8; i++) xr[i] = rnd_sample();
      send_block(xr, 1'b1);
      if (b % 4 == 3) begin
        in_valid = 1'b0;
        drain();
      end
    end
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
